// File: rtl/array_sequencer.sv
// Sequencer for an NxN multiply-accumulate PE array: walks LOAD/COMPUTE/DRAIN per tile
// and decodes per-PE operand selects, add-zero controls and per-row accumulator strobes.

module array_sequencer_row #(
  parameter int N     = 4,
  parameter int ROW   = 0,
  parameter int CNT_W = 8
) (
  input  logic [1:0]     i_sel,
  input  logic           i_mac,
  input  logic           i_strobe,
  input  logic [CNT_W:0] i_cnt,
  output logic [2*N-1:0] o_mux,
  output logic [N-1:0]   o_az,
  output logic           o_av
);
  assign o_mux = {N{i_sel}};
  // Only row 0 starts a fresh sum; lower rows take the partial sum from above.
  assign o_az  = (ROW == 0) ? {N{i_mac}} : '0;
  assign o_av  = i_strobe && (i_cnt == (CNT_W+1)'(ROW));
endmodule

module array_sequencer #(
  parameter int N      = 4,
  parameter int CNT_W  = 8,
  parameter int TILE_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                ready_i,
  input  logic [CNT_W-1:0]    k_len_i,
  input  logic [TILE_W-1:0]   tiles_i,
  output logic [2*N*N-1:0]    mux_o,
  output logic [N*N-1:0]      add_zero_o,
  output logic [N-1:0]        acc_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [TILE_W-1:0]   tile_idx_o
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_COMP = 2'd2;

  state_t              r_state;
  logic [CNT_W:0]      r_cnt;
  logic [TILE_W-1:0]   r_tile;
  logic [CNT_W-1:0]    r_k;
  logic [TILE_W-1:0]   r_t;

  logic                w_run;
  logic                w_n_end;
  logic                w_k_end;
  logic                w_last;
  logic [CNT_W:0]      w_k_lim;
  logic [1:0]          w_sel;
  logic                w_mac;
  logic                w_strobe;

  assign w_run   = (r_state == S_LOAD) || (r_state == S_COMP) || (r_state == S_DRAIN);
  assign w_n_end = (r_cnt == (CNT_W+1)'(N-1));
  // One extra counter bit keeps K+N-2 exact at the largest K.
  assign w_k_lim = {1'b0, r_k} + (CNT_W+1)'(N-2);
  assign w_k_end = (r_cnt == w_k_lim);
  assign w_last  = ({1'b0, r_tile} + (TILE_W+1)'(1)) >= {1'b0, r_t};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tile  <= '0;
      r_k     <= '0;
      r_t     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_k     <= (k_len_i == '0) ? CNT_W'(1) : k_len_i;
            r_t     <= (tiles_i == '0) ? TILE_W'(1) : tiles_i;
            r_cnt   <= '0;
            r_tile  <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (ready_i) begin
            if (w_n_end) begin
              r_cnt   <= '0;
              r_state <= S_COMP;
            end else begin
              r_cnt <= r_cnt + (CNT_W+1)'(1);
            end
          end
        end
        S_COMP: begin
          if (ready_i) begin
            if (w_k_end) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + (CNT_W+1)'(1);
            end
          end
        end
        S_DRAIN: begin
          if (ready_i) begin
            if (w_n_end) begin
              r_cnt <= '0;
              if (w_last) begin
                r_state <= S_DONE;
              end else begin
                r_tile  <= r_tile + TILE_W'(1);
                r_state <= S_LOAD;
              end
            end else begin
              r_cnt <= r_cnt + (CNT_W+1)'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A stalled cycle holds every PE; add-zero follows state so partial sums stay consistent.
  assign w_sel    = (!w_run || !ready_i) ? SEL_HOLD :
                    (r_state == S_LOAD)  ? SEL_LOAD : SEL_COMP;
  assign w_mac    = (r_state == S_COMP) || (r_state == S_DRAIN);
  assign w_strobe = (r_state == S_DRAIN) && ready_i;

  for (genvar r = 0; r < N; r++) begin : g_row
    array_sequencer_row #(.N(N), .ROW(r), .CNT_W(CNT_W)) u_row (
      .i_sel    (w_sel),
      .i_mac    (w_mac),
      .i_strobe (w_strobe),
      .i_cnt    (r_cnt),
      .o_mux    (mux_o[r*2*N +: 2*N]),
      .o_az     (add_zero_o[r*N +: N]),
      .o_av     (acc_valid_o[r])
    );
  end

  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign tile_idx_o = (r_state == S_IDLE) ? '0 : r_tile;
endmodule

// File: tb/tb_array_sequencer.sv
// Directed bench for array_sequencer: expected per-cycle outputs are queued as
// stimulus is driven and compared against the DUT mid-cycle.

module tb_array_sequencer;
  localparam int N      = 4;
  localparam int CNT_W  = 8;
  localparam int TILE_W = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_COMP  = 2;
  localparam int PH_DRAIN = 3;
  localparam int PH_DONE  = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                start_i = 1'b0;
  logic                ready_i = 1'b0;
  logic [CNT_W-1:0]    k_len_i = '0;
  logic [TILE_W-1:0]   tiles_i = '0;
  logic [2*N*N-1:0]    mux_o;
  logic [N*N-1:0]      add_zero_o;
  logic [N-1:0]        acc_valid_o;
  logic                busy_o;
  logic                done_o;
  logic [TILE_W-1:0]   tile_idx_o;

  array_sequencer #(.N(N), .CNT_W(CNT_W), .TILE_W(TILE_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .ready_i     (ready_i),
    .k_len_i     (k_len_i),
    .tiles_i     (tiles_i),
    .mux_o       (mux_o),
    .add_zero_o  (add_zero_o),
    .acc_valid_o (acc_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tile_idx_o  (tile_idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2*N*N-1:0]  mux;
    logic [N*N-1:0]    az;
    logic [N-1:0]      av;
    logic              busy;
    logic              done;
    logic [TILE_W-1:0] tidx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   passed   = 0;
  int   cyc      = 0;
  int   av_cnt   = 0;
  int   done_cnt = 0;

  function automatic exp_t ex(int ph, int tile, int d, bit stall);
    exp_t e;
    e      = '0;
    e.busy = (ph != PH_IDLE);
    e.done = (ph == PH_DONE);
    e.tidx = (ph == PH_IDLE) ? '0 : TILE_W'(tile);
    if (ph == PH_LOAD && !stall) e.mux = {N*N{2'b01}};
    if ((ph == PH_COMP || ph == PH_DRAIN) && !stall) e.mux = {N*N{2'b10}};
    if (ph == PH_COMP || ph == PH_DRAIN) e.az = (N*N)'((1 << N) - 1);
    if (ph == PH_DRAIN && !stall) e.av = N'(1 << d);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.mux  = mux_o;
    e.az   = add_zero_o;
    e.av   = acc_valid_o;
    e.busy = busy_o;
    e.done = done_o;
    e.tidx = tile_idx_o;
    return e;
  endfunction

  task automatic check(string tag, exp_t got, exp_t want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, want);
  endtask

  task automatic chk_int(string tag, int got, int want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, want);
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
  task automatic tick(string tag, bit st, bit rd, exp_t e);
    exp_q.push_back(e);
    start_i = st;
    ready_i = rd;
    @(negedge clk_i);
    av_cnt += $countones(acc_valid_o);
    if (done_o) done_cnt++;
    check(tag, obs(), exp_q.pop_front());
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic phase(string tag, int ph, int tile, int d0, int n, bit st);
    for (int i = 0; i < n; i++) tick(tag, st, 1'b1, ex(ph, tile, d0 + i, 1'b0));
  endtask

  task automatic stall(string tag, int ph, int tile, int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 1'b0, ex(ph, tile, 0, 1'b1));
  endtask

  task automatic launch(string tag, int k, int t);
    k_len_i = CNT_W'(k);
    tiles_i = TILE_W'(t);
    cyc = 0; av_cnt = 0; done_cnt = 0;
    tick(tag, 1'b1, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    // Later input changes must not affect the running job.
    k_len_i = CNT_W'(k + 3);
    tiles_i = TILE_W'(t + 2);
  endtask

  task automatic plain_tile(string tag, int tile, int k);
    phase(tag, PH_LOAD, tile, 0, N, 1'b0);
    phase(tag, PH_COMP, tile, 0, k + N - 1, 1'b0);
    phase(tag, PH_DRAIN, tile, 0, N, 1'b0);
  endtask

  initial begin
    #1;
    check("reset_state", obs(), ex(PH_IDLE, 0, 0, 1'b0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick("idle_ready0", 1'b0, 1'b0, ex(PH_IDLE, 0, 0, 1'b0));

    // Single tile, K=4; ready ignored in DONE
    launch("t1_start", 4, 1);
    plain_tile("t1", 0, 4);
    chk_int("t1_done_cycle", cyc, 16);
    tick("t1_done", 1'b0, 1'b0, ex(PH_DONE, 0, 0, 1'b0));
    tick("t1_idle", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    chk_int("t1_strobes", av_cnt, N);
    chk_int("t1_dones", done_cnt, 1);

    // Three-cycle stall mid-COMPUTE
    launch("t2_start", 4, 1);
    phase("t2_load", PH_LOAD, 0, 0, N, 1'b0);
    phase("t2_comp_a", PH_COMP, 0, 0, 3, 1'b0);
    stall("t2_stall", PH_COMP, 0, 3);
    phase("t2_comp_b", PH_COMP, 0, 0, 4, 1'b0);
    phase("t2_drain", PH_DRAIN, 0, 0, N, 1'b0);
    chk_int("t2_done_cycle", cyc, 19);
    tick("t2_done", 1'b0, 1'b1, ex(PH_DONE, 0, 0, 1'b0));
    tick("t2_idle", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    chk_int("t2_strobes", av_cnt, N);

    // Three tiles back to back
    launch("t3_start", 4, 3);
    for (int t = 0; t < 3; t++) plain_tile("t3", t, 4);
    chk_int("t3_done_cycle", cyc, 46);
    tick("t3_done", 1'b0, 1'b1, ex(PH_DONE, 2, 0, 1'b0));
    tick("t3_idle", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    chk_int("t3_strobes", av_cnt, 12);
    chk_int("t3_dones", done_cnt, 1);

    // K=0/T=0 clamp to 1; start while busy and in DONE ignored
    launch("t4_start", 0, 0);
    phase("t4_load", PH_LOAD, 0, 0, N, 1'b1);
    phase("t4_comp", PH_COMP, 0, 0, N, 1'b1);
    phase("t4_drain", PH_DRAIN, 0, 0, N, 1'b1);
    chk_int("t4_done_cycle", cyc, 13);
    tick("t4_done", 1'b1, 1'b1, ex(PH_DONE, 0, 0, 1'b0));
    for (int i = 0; i < 3; i++) tick("t4_idle", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    chk_int("t4_dones", done_cnt, 1);

    // Asynchronous reset mid-DRAIN, then a fresh full tile
    launch("t5_start", 4, 1);
    phase("t5_load", PH_LOAD, 0, 0, N, 1'b0);
    phase("t5_comp", PH_COMP, 0, 0, 7, 1'b0);
    phase("t5_drain", PH_DRAIN, 0, 0, 2, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("t5_async_rst", obs(), ex(PH_IDLE, 0, 0, 1'b0));
    @(posedge clk_i); #1;
    check("t5_in_rst", obs(), ex(PH_IDLE, 0, 0, 1'b0));
    rst_ni = 1'b1;
    tick("t5_post_rst", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    launch("t5_restart", 4, 1);
    plain_tile("t5_rerun", 0, 4);
    tick("t5_done", 1'b0, 1'b1, ex(PH_DONE, 0, 0, 1'b0));
    tick("t5_idle", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    chk_int("t5_strobes", av_cnt, N);

    // K=255: COMPUTE spans 258 cycles without counter wrap
    launch("t6_start", 255, 1);
    plain_tile("t6", 0, 255);
    chk_int("t6_done_cycle", cyc, 1 + N + 258 + N);
    tick("t6_done", 1'b0, 1'b1, ex(PH_DONE, 0, 0, 1'b0));
    tick("t6_idle", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));

    // Stalls inside LOAD and DRAIN across a two-tile run
    launch("t7_start", 2, 2);
    phase("t7_load_a", PH_LOAD, 0, 0, 2, 1'b0);
    stall("t7_load_stall", PH_LOAD, 0, 2);
    phase("t7_load_b", PH_LOAD, 0, 2, 2, 1'b0);
    phase("t7_comp", PH_COMP, 0, 0, 2 + N - 1, 1'b0);
    phase("t7_drain_a", PH_DRAIN, 0, 0, 1, 1'b0);
    stall("t7_drain_stall", PH_DRAIN, 0, 3);
    phase("t7_drain_b", PH_DRAIN, 0, 1, N - 1, 1'b0);
    plain_tile("t7_tile1", 1, 2);
    tick("t7_done", 1'b0, 1'b1, ex(PH_DONE, 1, 0, 1'b0));
    tick("t7_idle", 1'b0, 1'b1, ex(PH_IDLE, 0, 0, 1'b0));
    chk_int("t7_strobes", av_cnt, 2 * N);
    chk_int("t7_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
